// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct values,
// ALU operation codes and write-register select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluXor = 3'd2;
    localparam logic [2:0] AluSlt = 3'd3;

    localparam logic [1:0] RegDstRt = 2'd0;
    localparam logic [1:0] RegDstRd = 2'd1;
    localparam logic [1:0] RegDstRa = 2'd2;

    // ALU operation for the register-register arithmetic functs.
    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        logic [2:0] op;
        case (funct)
            FnSub:   op = AluSub;
            FnSlt:   op = AluSlt;
            default: op = AluAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the captured IR to one-hot class flags
// plus the ALU operation for R-type arithmetic.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        op_j,
    output logic        op_jal,
    output logic        op_jr,
    output logic        op_alu_r,
    output logic        op_addi,
    output logic        op_xori,
    output logic        op_lw,
    output logic        op_sw,
    output logic        op_beq,
    output logic        op_bne,
    output logic        legal,
    output logic [2:0]  alu_r_op
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ir_bits;

    assign opcode         = ir[31:26];
    assign funct          = ir[5:0];
    // Register/immediate fields are consumed by the datapath, not the controller.
    assign unused_ir_bits = ^ir[25:6];

    always_comb begin
        op_j     = 1'b0;
        op_jal   = 1'b0;
        op_jr    = 1'b0;
        op_alu_r = 1'b0;
        op_addi  = 1'b0;
        op_xori  = 1'b0;
        op_lw    = 1'b0;
        op_sw    = 1'b0;
        op_beq   = 1'b0;
        op_bne   = 1'b0;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnJr:                op_jr    = 1'b1;
                    FnAdd, FnSub, FnSlt: op_alu_r = 1'b1;
                    default: ;
                endcase
            end
            OpJ:     op_j    = 1'b1;
            OpJal:   op_jal  = 1'b1;
            OpBeq:   op_beq  = 1'b1;
            OpBne:   op_bne  = 1'b1;
            OpAddi:  op_addi = 1'b1;
            OpXori:  op_xori = 1'b1;
            OpLw:    op_lw   = 1'b1;
            OpSw:    op_sw   = 1'b1;
            default: ;
        endcase
    end

    assign legal = op_j | op_jal | op_jr | op_alu_r | op_addi | op_xori |
                   op_lw | op_sw | op_beq | op_bne;

    assign alu_r_op = funct_alu_op(funct);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM with memory-wait timeout trap.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on illegal instructions instead of retiring them as NOPs.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        write_pc,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_jr,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic        mem_re,
    output logic [1:0]  reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        trap,
    output logic [2:0]  state
);

    localparam int unsigned WaitW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_WAIT_MAX);

    state_e           state_q, state_d;
    logic [31:0]      ir_q;
    logic [WaitW-1:0] wait_q, wait_d;

    logic       op_j, op_jal, op_jr, op_alu_r, op_addi, op_xori;
    logic       op_lw, op_sw, op_beq, op_bne, legal;
    logic [2:0] alu_r_op;

    mc_decode u_decode (
        .ir       (ir_q),
        .op_j     (op_j),
        .op_jal   (op_jal),
        .op_jr    (op_jr),
        .op_alu_r (op_alu_r),
        .op_addi  (op_addi),
        .op_xori  (op_xori),
        .op_lw    (op_lw),
        .op_sw    (op_sw),
        .op_beq   (op_beq),
        .op_bne   (op_bne),
        .legal    (legal),
        .alu_r_op (alu_r_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ir_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (ir_we) begin
                ir_q <= instr;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        write_pc   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_jr      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        reg_dst    = RegDstRt;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = AluAdd;
        trap       = 1'b0;

        case (state_q)
            StFetch: begin
                ir_we   = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (op_j || op_jal) begin
                    write_pc = 1'b1;
                    is_jump  = 1'b1;
                    if (op_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = RegDstRa;
                    end
                    state_d = StFetch;
                end else if (op_jr) begin
                    write_pc = 1'b1;
                    is_jr    = 1'b1;
                    state_d  = StFetch;
                end else if (legal) begin
                    state_d = StExec;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    write_pc = 1'b1;
                    state_d  = StFetch;
`endif
                end
            end
            StExec: begin
                if (op_alu_r) begin
                    alu_op  = alu_r_op;
                    state_d = StWb;
                end else if (op_addi) begin
                    alu_op  = AluAdd;
                    alu_src = 1'b1;
                    state_d = StWb;
                end else if (op_xori) begin
                    alu_op  = AluXor;
                    alu_src = 1'b1;
                    state_d = StWb;
                end else if (op_lw || op_sw) begin
                    alu_op  = AluAdd;
                    alu_src = 1'b1;
                    state_d = StMem;
                end else if (op_beq || op_bne) begin
                    alu_op    = AluSub;
                    write_pc  = 1'b1;
                    is_branch = op_beq ? zero : ~zero;
                    state_d   = StFetch;
                end else begin
                    state_d = StTrap;
                end
            end
            StMem: begin
                mem_re = op_lw;
                mem_we = op_sw;
                wait_d = wait_q;
                if (mem_ready) begin
                    if (op_sw) begin
                        write_pc = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_q == WaitMax) begin
                    // Counter already holds MEM_WAIT_MAX tolerated low cycles.
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                reg_we     = 1'b1;
                write_pc   = 1'b1;
                reg_dst    = op_alu_r ? RegDstRd : RegDstRt;
                mem_to_reg = op_lw;
                state_d    = StFetch;
            end
            StTrap: begin
                trap    = 1'b1;
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: an instruction-level reference model queues the
// expected per-cycle control outputs, and a negedge monitor compares them against the DUT.
module tb_mc_ctrl;

    localparam int unsigned MaxWait = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        write_pc, is_branch, is_jump, is_jr;
    logic        ir_we, reg_we, mem_we, mem_re;
    logic [1:0]  reg_dst;
    logic        mem_to_reg, alu_src;
    logic [2:0]  alu_op;
    logic        trap;
    logic [2:0]  state;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_WAIT_MAX(MaxWait)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .write_pc   (write_pc),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_jr      (is_jr),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .trap       (trap),
        .state      (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       wpc;
        logic       br;
        logic       jmp;
        logic       jr;
        logic       irwe;
        logic       regwe;
        logic       memwe;
        logic       memre;
        logic [1:0] rdst;
        logic       m2r;
        logic       asrc;
        logic [2:0] aop;
        logic       trap;
    } exp_t;

    typedef enum {CAdd, CSub, CSlt, CJr, CJ, CJal, CAddi, CXori, CLw, CSw, CBeq, CBne, CIll} cls_e;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Monitor: one expected record per clock cycle while the queue is non-empty.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a = {state, write_pc, is_branch, is_jump, is_jr, ir_we, reg_we, mem_we, mem_re,
                 reg_dst, mem_to_reg, alu_src, alu_op, trap};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s got st=%0d wpc=%b br=%b j=%b jr=%b irwe=%b rwe=%b mwe=%b mre=%b rdst=%0d m2r=%b asrc=%b aop=%0d trap=%b | want st=%0d wpc=%b br=%b j=%b jr=%b irwe=%b rwe=%b mwe=%b mre=%b rdst=%0d m2r=%b asrc=%b aop=%0d trap=%b",
                         nm, a.st, a.wpc, a.br, a.jmp, a.jr, a.irwe, a.regwe, a.memwe, a.memre,
                         a.rdst, a.m2r, a.asrc, a.aop, a.trap, e.st, e.wpc, e.br, e.jmp, e.jr,
                         e.irwe, e.regwe, e.memwe, e.memre, e.rdst, e.m2r, e.asrc, e.aop, e.trap);
            end
        end
    end

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic cls_e classify(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   return CAdd;
                    6'h22:   return CSub;
                    6'h2A:   return CSlt;
                    6'h08:   return CJr;
                    default: return CIll;
                endcase
            end
            6'h02:   return CJ;
            6'h03:   return CJal;
            6'h04:   return CBeq;
            6'h05:   return CBne;
            6'h08:   return CAddi;
            6'h0E:   return CXori;
            6'h23:   return CLw;
            6'h2B:   return CSw;
            default: return CIll;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input cls_e c);
        case (c)
            CSub:    return 3'd1;
            CSlt:    return 3'd3;
            CXori:   return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] gen(input cls_e c);
        logic [31:0] w;
        logic [5:0]  code;
        w = $urandom;
        case (c)
            CAdd:  begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            CSub:  begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
            CSlt:  begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
            CJr:   begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
            CJ:    w[31:26] = 6'h02;
            CJal:  w[31:26] = 6'h03;
            CAddi: w[31:26] = 6'h08;
            CXori: w[31:26] = 6'h0E;
            CLw:   w[31:26] = 6'h23;
            CSw:   w[31:26] = 6'h2B;
            CBeq:  w[31:26] = 6'h04;
            CBne:  w[31:26] = 6'h05;
            default: begin
                // Either an unknown opcode or an unknown R-type funct.
                if (rbit()) begin
                    w[31:26] = 6'h00;
                    for (int t = 0; t < 20; t++) begin
                        code = 6'($urandom_range(0, 63));
                        if (!(code inside {6'h08, 6'h20, 6'h22, 6'h2A})) break;
                    end
                    if (code inside {6'h08, 6'h20, 6'h22, 6'h2A}) code = 6'h3F;
                    w[5:0] = code;
                end else begin
                    for (int t = 0; t < 20; t++) begin
                        code = 6'($urandom_range(1, 63));
                        if (!(code inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E,
                                           6'h23, 6'h2B})) break;
                    end
                    if (code inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h23, 6'h2B})
                        code = 6'h3F;
                    w[31:26] = code;
                end
            end
        endcase
        return w;
    endfunction

    // Drive one cycle of inputs, queue its expected outputs, advance to just after the edge.
    task automatic cyc(input exp_t e, input string nm, input logic [31:0] ins, input logic z,
                       input logic mr, input logic rst);
        instr     = ins;
        zero      = z;
        mem_ready = mr;
        reset     = rst;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic trap_then_reset(input string tag);
        exp_t e;
        e = blank(3'd5);
        e.trap = 1'b1;
        cyc(e, {tag, ".trap"}, $urandom, rbit(), rbit(), 1'b0);
        cyc(e, {tag, ".trap"}, $urandom, rbit(), rbit(), 1'b0);
        cyc(e, {tag, ".trap_rst"}, $urandom, rbit(), rbit(), 1'b1);
    endtask

    // Reference model: one instruction from FETCH to retirement (or trap / reset abort).
    task automatic run_instr(input logic [31:0] ins, input int waits, input int zsel,
                             input int rst_at, input string tag);
        cls_e c;
        exp_t e;
        logic z;
        logic ready;
        logic done;
        c = classify(ins);

        e = blank(3'd0);
        e.irwe = 1'b1;
        cyc(e, {tag, ".fetch"}, ins, rbit(), rbit(), 1'b0);

        e = blank(3'd1);
        case (c)
            CJ: begin
                e.wpc = 1'b1; e.jmp = 1'b1;
                cyc(e, {tag, ".decode"}, $urandom, rbit(), rbit(), 1'b0);
                return;
            end
            CJal: begin
                e.wpc = 1'b1; e.jmp = 1'b1; e.regwe = 1'b1; e.rdst = 2'd2;
                cyc(e, {tag, ".decode"}, $urandom, rbit(), rbit(), 1'b0);
                return;
            end
            CJr: begin
                e.wpc = 1'b1; e.jr = 1'b1;
                cyc(e, {tag, ".decode"}, $urandom, rbit(), rbit(), 1'b0);
                return;
            end
            CIll: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                cyc(e, {tag, ".decode"}, $urandom, rbit(), rbit(), 1'b0);
                trap_then_reset(tag);
`else
                e.wpc = 1'b1;
                cyc(e, {tag, ".decode"}, $urandom, rbit(), rbit(), 1'b0);
`endif
                return;
            end
            default: cyc(e, {tag, ".decode"}, $urandom, rbit(), rbit(), 1'b0);
        endcase

        e = blank(3'd2);
        if (c == CBeq || c == CBne) begin
            z = (zsel < 0) ? rbit() : zsel[0];
            e.aop = 3'd1;
            e.wpc = 1'b1;
            e.br  = (c == CBeq) ? z : ~z;
            cyc(e, {tag, ".exec"}, $urandom, z, rbit(), 1'b0);
            return;
        end
        e.aop  = alu_of(c);
        e.asrc = (c inside {CAddi, CXori, CLw, CSw});
        cyc(e, {tag, ".exec"}, $urandom, rbit(), rbit(), 1'b0);

        if (c == CLw || c == CSw) begin
            done = 1'b0;
            for (int k = 0; k <= int'(MaxWait) && !done; k++) begin
                ready = (k == waits);
                e = blank(3'd3);
                e.memre = (c == CLw);
                e.memwe = (c == CSw);
                if (k == rst_at) begin
                    cyc(e, {tag, ".mem_rst"}, $urandom, rbit(), 1'b0, 1'b1);
                    return;
                end
                e.wpc = ready && (c == CSw);
                cyc(e, {tag, ".mem"}, $urandom, rbit(), ready, 1'b0);
                done = ready;
            end
            if (!done) begin
                // MaxWait+1 consecutive low cycles.
                trap_then_reset(tag);
                return;
            end
            if (c == CSw) return;
        end

        e = blank(3'd4);
        e.regwe = 1'b1;
        e.wpc   = 1'b1;
        e.rdst  = (c inside {CAdd, CSub, CSlt}) ? 2'd1 : 2'd0;
        e.m2r   = (c == CLw);
        cyc(e, {tag, ".wb"}, $urandom, rbit(), rbit(), 1'b0);
    endtask

    initial begin
        exp_t e;
        cls_e c;
        int   r;
        int   waits;
        int   rst_at;

        reset     = 1'b1;
        instr     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        e = blank(3'd0);
        e.irwe = 1'b1;
        cyc(e, "reset.fetch", $urandom, rbit(), rbit(), 1'b1);
        cyc(e, "reset.fetch", $urandom, rbit(), rbit(), 1'b1);

        run_instr(32'h012A4020, 0, -1, -1, "add");
        run_instr(32'h11090003, 0, 1, -1, "beq_z1");
        run_instr(32'h11090003, 0, 0, -1, "beq_z0");
        run_instr(32'h8D090004, 2, -1, -1, "lw_w2");
        run_instr(32'h0C000007, 0, -1, -1, "jal");
        run_instr(32'hAD090004, 16, -1, -1, "sw_w16");
        run_instr(32'hAD090004, 15, -1, -1, "sw_w15");
        run_instr(32'h8D090004, 5, -1, 2, "lw_rst");
        run_instr(32'hFC000000, 0, -1, -1, "op3f");
        run_instr(32'h01095022, 0, -1, -1, "sub");

        for (int i = 0; i < 250; i++) begin
            c = cls_e'($urandom_range(0, 12));
            r = int'($urandom_range(0, 39));
            waits = (r == 0) ? 16 : (r == 1) ? 15 : int'($urandom_range(0, 3));
            rst_at = (waits >= 2 && $urandom_range(0, 19) == 0) ? 1 : -1;
            run_instr(gen(c), waits, -1, rst_at, "rnd");
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum consecutive MEM-state cycles with mem_ready low before a timeout trap.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 instr  input  32  instruction word from the fetch unit's out port.
REQ-005 zero  input  1  ALU zero flag; valid in EXEC.
REQ-006 mem_ready  input  1  data-memory ready; completes the access in MEM.
REQ-007 write_pc  output  1  PC update strobe to the fetch unit.
REQ-008 is_branch, is_jump, is_jr  output  1 each  PC source selects; each is qualified by write_pc.
REQ-009 ir_we, reg_we, mem_we, mem_re  output  1 each  IR capture, register write, memory write and memory read enables.
REQ-010 reg_dst[1:0]  output  2  write-register select: 0=rt, 1=rd, 2=$31.
REQ-011 mem_to_reg, alu_src  output  1 each  writeback source select and ALU B-operand select (1 = immediate).
REQ-012 alu_op  output  3  ALU operation: 0=ADD, 1=SUB, 2=XOR, 3=SLT.
REQ-013 trap  output  1  sticky fault flag.
REQ-014 state  output  3  current state code, for debug.

Function
REQ-015 The block SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; all other codes SHALL go to TRAP.
REQ-016 FETCH: ir_we=1 and instr captured into the internal IR at the clock edge; next state DECODE.
REQ-017 DECODE, opcode-dependent:
- J (0x02): write_pc=1, is_jump=1; next state FETCH.
- JAL (0x03): same as J, plus reg_we=1 and reg_dst=2.
- R-type JR (funct 0x08): write_pc=1, is_jr=1; next state FETCH.
- All other legal opcodes: next state EXEC.
REQ-018 EXEC, per instruction class:
- ADD/SUB/SLT (funct 0x20/0x22/0x2A): alu_op per funct, alu_src=0.
- ADDI (0x08): alu_op=ADD, alu_src=1.
- XORI (0x0E): alu_op=XOR, alu_src=1.
- LW (0x23) and SW (0x2B): alu_op=ADD, alu_src=1.
- BEQ (0x04) and BNE (0x05): alu_op=SUB; write_pc=1; is_branch=zero for BEQ, ~zero for BNE; next state FETCH.
- Arithmetic instructions go to WB; LW and SW go to MEM.
REQ-019 MEM: mem_re=1 (LW) or mem_we=1 (SW) while held. On mem_ready=1, LW goes to WB; SW asserts write_pc=1 and goes to FETCH. If mem_ready=0, the block stays in MEM.
REQ-020 WB: reg_we=1 and write_pc=1 (sequential). reg_dst=1 for R-type, else 0. mem_to_reg=1 only for LW. Next state FETCH.
REQ-021 A wait counter SHALL clear on MEM entry and increment each MEM cycle with mem_ready=0. When the counter reaches MEM_WAIT_MAX, next state is TRAP. With MEM_WAIT_MAX=15, 15 low cycles are tolerated and the 16th low cycle traps.
REQ-022 TRAP: trap=1, and all enables and write_pc=0. TRAP is left only by reset.
REQ-023 Outputs SHALL be combinational from state, IR, zero and mem_ready only. Outputs not specified for a state are 0.
REQ-024 write_pc SHALL assert exactly once per retired instruction.

Reset
REQ-025 When reset is high at an edge, the next state is FETCH, IR=0, the wait counter is 0 and trap=0, overriding any state including MEM mid-wait and TRAP.
REQ-026 During and immediately after reset, all enables and write_pc SHALL be 0 except ir_we, which is 1 in FETCH.

Configuration
REQ-027 The macro MC_CTRL_ILLEGAL_TRAP_EN selects illegal-opcode handling.
- Defined: an unsupported opcode or funct in DECODE goes to TRAP.
- Undefined: the instruction executes as a NOP; DECODE asserts write_pc=1 and goes to FETCH.

Structure
REQ-028 A shared package SHALL hold the state encoding, opcode/funct constants, alu_op codes and reg_dst codes.
REQ-029 A combinational sub-module mc_decode SHALL map IR to instruction-class flags. mc_ctrl holds the FSM and the wait counter.

Verification
REQ-030 instr=0x012A4020 (ADD) -> 4 cycles; WB has reg_we=1, reg_dst=1, write_pc=1; alu_op=0 in EXEC.
REQ-031 instr=0x11090003 (BEQ): zero=1 -> EXEC write_pc=1, is_branch=1. zero=0 -> write_pc=1, is_branch=0. Both take 3 cycles.
REQ-032 instr=0x8D090004 (LW), mem_ready low 2 cycles -> MEM held 3 cycles with mem_re=1; WB has mem_to_reg=1; 7 cycles total.
REQ-033 instr=0x0C000007 (JAL) -> DECODE has write_pc=1, is_jump=1, reg_we=1, reg_dst=2; 2 cycles.
REQ-034 SW with mem_ready held low for 16 cycles -> trap=1 and state=5; subsequent reset pulse -> state=0, trap=0.
REQ-035 Opcode 0x3F, with the macro defined -> TRAP; without the macro -> NOP, write_pc=1, 2 cycles.
